spram_arbiter: RTL and testbench
================================

SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width of the shared RAM.
REQ-002 The block SHALL have parameter DEPTH, default 32, word count of the shared RAM; AW = $clog2(DEPTH).
REQ-003 The block SHALL have port clk  input  1  clock, all state updates on posedge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port arb_en  input  1  when low, no new grants are issued.
REQ-006 The block SHALL have ports req_valid_k  input  1  request present, for k = 0,1.
REQ-007 The block SHALL have ports req_ready_k  output  1  request accepted this cycle, for k = 0,1.
REQ-008 The block SHALL have ports req_we_k  input  1  1 = write, 0 = read, for k = 0,1.
REQ-009 The block SHALL have ports req_addr_k  input  AW  word address, for k = 0,1.
REQ-010 The block SHALL have ports req_wdata_k  input  WIDTH  write data, for k = 0,1.
REQ-011 The block SHALL have ports resp_valid_k  output  1  read data valid pulse, for k = 0,1.
REQ-012 The block SHALL have ports resp_rdata_k  output  WIDTH  read data, for k = 0,1.
REQ-013 The block SHALL have ports ram_en / ram_we  output  1  RAM read enable / write enable.
REQ-014 The block SHALL have port ram_addr  output  AW  RAM address.
REQ-015 The block SHALL have port ram_din  output  WIDTH  RAM write data.
REQ-016 The block SHALL have port ram_dout  input  WIDTH  RAM registered read data, 1-cycle latency.
REQ-017 The block SHALL have ports grant_cnt_k  output  16  saturating count of accepted requests, for k = 0,1.

Function
REQ-018 The block SHALL accept at most one request per cycle, with no more than one of req_ready_0 and req_ready_1 high.
REQ-019 The block SHALL drive req_ready_k combinationally as arb_en & req_valid_k & (no competing valid, or port k holds priority).
REQ-020 The block SHALL implement round-robin priority: register last_gnt updates on each accept, and the port not last granted wins a conflict.
REQ-021 The block SHALL drive ram_addr, ram_din and ram_we from the accepted port in the same cycle, with ram_en = 1 for reads.
REQ-022 The block SHALL hold ram_en = ram_we = 0 in cycles with no accept; ram_addr and ram_din are don't-care but SHALL be driven from port 0.
REQ-023 For a read accepted in cycle T, the block SHALL assert resp_valid_k for exactly cycle T+1, with resp_rdata_k = ram_dout.
REQ-024 The block SHALL produce no response for writes.
REQ-025 The block SHALL track the response owner with a one-deep pipeline register (pend_valid, pend_port).
REQ-026 The block SHALL drive resp_rdata_k = 0 whenever resp_valid_k = 0.
REQ-027 The block SHALL sustain back-to-back accepts, one per cycle, including read-after-write to the same address; such a read at T+1 SHALL return the data written at T.
REQ-028 The block SHALL increment grant_cnt_k on each accept of port k and saturate it at 16'hFFFF.
REQ-029 When arb_en falls, the block SHALL still deliver an already-issued response in the next cycle.
REQ-030 The block SHALL leave last_gnt unchanged in cycles with no accept.

Reset
REQ-031 In a cycle with rst high, the block SHALL force req_ready_k = 0 and ram_en = ram_we = 0 combinationally.
REQ-032 After reset, the block SHALL hold resp_valid_k = 0, resp_rdata_k = 0, pend_valid = 0, grant_cnt_k = 0, and last_gnt = 1, so port 0 wins the first conflict.
REQ-033 A rst asserted in the cycle after a read accept SHALL discard the pending response, and no resp_valid SHALL pulse.

Verification
REQ-034 The bench SHALL cover: both ports valid continuously for 6 cycles with arb_en = 1 -> grants 0,1,0,1,0,1; grant_cnt_0 = grant_cnt_1 = 3.
REQ-035 The bench SHALL cover: port 0 writes 0xDEADBEEF to addr 5 at T, port 1 reads addr 5 at T+1 -> resp_valid_1 = 1 at T+2 with rdata 0xDEADBEEF; resp_valid_0 stays 0.
REQ-036 The bench SHALL cover: only port 1 valid, reading addr 3 (preloaded 0x12) -> req_ready_1 = 1 in the same cycle; resp_valid_1 pulses one cycle later with 0x12.
REQ-037 The bench SHALL cover: arb_en = 0 with both ports valid for 4 cycles -> no ready, ram_en = ram_we = 0, counters unchanged.
REQ-038 The bench SHALL cover: read accept at T and rst = 1 at T+1 -> resp_valid_k = 0 at T+1 and T+2; after reset, the first conflict is granted to port 0.
REQ-039 The bench SHALL cover: grant_cnt_0 forced near saturation by 70000 port-0 accepts -> grant_cnt_0 = 16'hFFFF and holds.

Source files
------------

// File: rtl/spram_arbiter.sv
// spram_arbiter
//   Two-port round-robin arbiter in front of a single-port RAM with a
//   registered (1-cycle) read port. At most one request is accepted per
//   cycle. The accepted request drives the RAM in the same cycle. A read
//   returns its data to the requesting port in the following cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   arb_en            when low, no new grants are issued
//   req_*_0/1         request channel per port (valid/ready/we/addr/wdata)
//   resp_*_0/1        read response per port (single-cycle valid pulse)
//   ram_*             RAM side: en (read enable), we, addr, din, dout
//   grant_cnt_0/1     saturating 16-bit count of accepted requests
module spram_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arb_en,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic             req_we_0,
  input  logic [AW-1:0]    req_addr_0,
  input  logic [WIDTH-1:0] req_wdata_0,
  output logic             resp_valid_0,
  output logic [WIDTH-1:0] resp_rdata_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic             req_we_1,
  input  logic [AW-1:0]    req_addr_1,
  input  logic [WIDTH-1:0] req_wdata_1,
  output logic             resp_valid_1,
  output logic [WIDTH-1:0] resp_rdata_1,
  output logic             ram_en,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [15:0]      grant_cnt_0,
  output logic [15:0]      grant_cnt_1
);

  logic gnt_0;
  logic gnt_1;
  logic last_gnt;    // port granted most recently; the other port wins a tie
  logic pend_valid;  // a read was accepted last cycle
  logic pend_port;   // owner of that read

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    if (cnt == 16'hFFFF) begin
      return cnt;
    end else begin
      return cnt + 16'd1;
    end
  endfunction

  // Grant decision: a lone request wins; on a tie the port not last granted wins.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (!rst && arb_en) begin
      gnt_0 = req_valid_0 & (~req_valid_1 | last_gnt);
      gnt_1 = req_valid_1 & (~req_valid_0 | ~last_gnt);
    end else begin
      gnt_0 = 1'b0;
      gnt_1 = 1'b0;
    end
  end

  assign req_ready_0 = gnt_0;
  assign req_ready_1 = gnt_1;

  // RAM command mux; idle cycles still present port 0's address and data.
  always_comb begin
    ram_addr = req_addr_0;
    ram_din  = req_wdata_0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    if (gnt_1) begin
      ram_addr = req_addr_1;
      ram_din  = req_wdata_1;
      ram_en   = ~req_we_1;
      ram_we   = req_we_1;
    end else if (gnt_0) begin
      ram_en   = ~req_we_0;
      ram_we   = req_we_0;
    end else begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
    end
  end

  // Response routing: RAM output arrives one cycle after the read accept, so
  // the valid is decoded from the pending register. Gating with rst drops a
  // response whose cycle coincides with reset.
  assign resp_valid_0 = pend_valid & ~pend_port & ~rst;
  assign resp_valid_1 = pend_valid &  pend_port & ~rst;
  assign resp_rdata_0 = resp_valid_0 ? ram_dout : {WIDTH{1'b0}};
  assign resp_rdata_1 = resp_valid_1 ? ram_dout : {WIDTH{1'b0}};

  // Arbitration state, response owner pipeline and grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_port   <= 1'b0;
      last_gnt    <= 1'b1;
      grant_cnt_0 <= 16'h0000;
      grant_cnt_1 <= 16'h0000;
    end else begin
      pend_valid <= ram_en;
      pend_port  <= gnt_1;
      if (gnt_0) begin
        last_gnt    <= 1'b0;
        grant_cnt_0 <= sat_inc(grant_cnt_0);
      end else if (gnt_1) begin
        last_gnt    <= 1'b1;
        grant_cnt_1 <= sat_inc(grant_cnt_1);
      end else begin
        last_gnt    <= last_gnt;
      end
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: a behavioural RAM, a transaction-level
// reference model checked every cycle, directed scenarios with literal
// expectations, and randomized traffic.
module tb_spram_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst, arb_en;
  logic             req_valid_0, req_ready_0, req_we_0;
  logic [AW-1:0]    req_addr_0;
  logic [WIDTH-1:0] req_wdata_0;
  logic             resp_valid_0;
  logic [WIDTH-1:0] resp_rdata_0;
  logic             req_valid_1, req_ready_1, req_we_1;
  logic [AW-1:0]    req_addr_1;
  logic [WIDTH-1:0] req_wdata_1;
  logic             resp_valid_1;
  logic [WIDTH-1:0] resp_rdata_1;
  logic             ram_en, ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_din, ram_dout;
  logic [15:0]      grant_cnt_0, grant_cnt_1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
    .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .resp_valid_0(resp_valid_0), .resp_rdata_0(resp_rdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .resp_valid_1(resp_valid_1), .resp_rdata_1(resp_rdata_1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [WIDTH-1:0] init_val(input int i);
    return (i == 3) ? 32'h0000_0012 : (32'hA500_0000 | 32'(i));
  endfunction

  // Behavioural single-port RAM, contents restored while rst is high.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  // Reference model: transaction level state.
  bit               m_init = 1'b0;
  int               m_pref;          // port that wins the next tie
  int               m_cnt [2];
  bit               m_pend_valid;
  int               m_pend_port;
  logic [WIDTH-1:0] m_pend_data;
  logic [WIDTH-1:0] shadow [DEPTH];

  bit               c_acc, c_we;
  int               c_p;
  logic [AW-1:0]    c_addr;
  logic [WIDTH-1:0] c_data;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready_0", req_ready_0, 32'd0);
      check("rst_ready_1", req_ready_1, 32'd0);
      check("rst_ram_en", ram_en, 32'd0);
      check("rst_ram_we", ram_we, 32'd0);
      check("rst_resp_valid_0", resp_valid_0, 32'd0);
      check("rst_resp_valid_1", resp_valid_1, 32'd0);
      check("rst_resp_rdata_0", resp_rdata_0, 32'd0);
      check("rst_resp_rdata_1", resp_rdata_1, 32'd0);
      m_init = 1'b1;
      m_pref = 0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_pend_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
    end else if (m_init) begin
      c_acc = 1'b0;
      c_p = 0;
      if (arb_en && req_valid_0 && req_valid_1) begin c_acc = 1'b1; c_p = m_pref; end
      else if (arb_en && req_valid_0)            begin c_acc = 1'b1; c_p = 0; end
      else if (arb_en && req_valid_1)            begin c_acc = 1'b1; c_p = 1; end
      c_we   = (c_p == 1) ? req_we_1    : req_we_0;
      c_addr = (c_p == 1) ? req_addr_1  : req_addr_0;
      c_data = (c_p == 1) ? req_wdata_1 : req_wdata_0;

      check("ready_0", req_ready_0, 32'(c_acc && c_p == 0));
      check("ready_1", req_ready_1, 32'(c_acc && c_p == 1));
      check("ram_en", ram_en, 32'(c_acc && !c_we));
      check("ram_we", ram_we, 32'(c_acc && c_we));
      check("ram_addr", 32'(ram_addr), 32'(c_addr));
      check("ram_din", ram_din, c_data);
      check("resp_valid_0", resp_valid_0, 32'(m_pend_valid && m_pend_port == 0));
      check("resp_valid_1", resp_valid_1, 32'(m_pend_valid && m_pend_port == 1));
      check("resp_rdata_0", resp_rdata_0, (m_pend_valid && m_pend_port == 0) ? m_pend_data : 32'd0);
      check("resp_rdata_1", resp_rdata_1, (m_pend_valid && m_pend_port == 1) ? m_pend_data : 32'd0);
      check("grant_cnt_0", 32'(grant_cnt_0), 32'(m_cnt[0]));
      check("grant_cnt_1", 32'(grant_cnt_1), 32'(m_cnt[1]));

      m_pend_valid = c_acc && !c_we;
      m_pend_port  = c_p;
      m_pend_data  = shadow[c_addr];
      if (c_acc) begin
        if (c_we) shadow[c_addr] = c_data;
        m_pref = 1 - c_p;
        if (m_cnt[c_p] < 65535) m_cnt[c_p]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
    req_valid_0 = v0; req_we_0 = w0; req_addr_0 = a0; req_wdata_0 = d0;
    req_valid_1 = v1; req_we_1 = w1; req_addr_1 = a1; req_wdata_1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    arb_en = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("lit_reset_cnt_0", 32'(grant_cnt_0), 32'd0);
    check("lit_reset_cnt_1", 32'(grant_cnt_1), 32'd0);
    check("lit_reset_resp_0", resp_valid_0, 32'd0);

    // Both ports requesting continuously: strict alternation starting at port 0.
    arb_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(1'b1, 1'b0, 5'(i), 32'd0, 1'b1, 1'b0, 5'(i + 8), 32'd0);
      #1;
      check("lit_rr_ready_0", req_ready_0, 32'(i % 2 == 0));
      check("lit_rr_ready_1", req_ready_1, 32'(i % 2 == 1));
    end
    tick(); idle(); #1;
    check("lit_rr_cnt_0", 32'(grant_cnt_0), 32'd3);
    check("lit_rr_cnt_1", 32'(grant_cnt_1), 32'd3);

    // Write on port 0 followed immediately by a read of the same word on port 1.
    tick(); drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0); #1;
    check("lit_raw_wr_ready_0", req_ready_0, 32'd1);
    tick(); drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 32'd0); #1;
    check("lit_raw_rd_ready_1", req_ready_1, 32'd1);
    tick(); idle(); #1;
    check("lit_raw_resp_valid_1", resp_valid_1, 32'd1);
    check("lit_raw_resp_rdata_1", resp_rdata_1, 32'hDEADBEEF);
    check("lit_raw_resp_valid_0", resp_valid_0, 32'd0);

    // Lone port 1 read of the preloaded word.
    tick(); drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd3, 32'd0); #1;
    check("lit_solo_ready_1", req_ready_1, 32'd1);
    tick(); idle(); #1;
    check("lit_solo_resp_valid_1", resp_valid_1, 32'd1);
    check("lit_solo_resp_rdata_1", resp_rdata_1, 32'h12);

    // Arbitration disabled: no grants, no RAM activity, counters frozen.
    arb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1'b1, 1'b1, 5'd9, 32'h1111, 1'b1, 1'b1, 5'd10, 32'h2222); #1;
      check("lit_dis_ready_0", req_ready_0, 32'd0);
      check("lit_dis_ready_1", req_ready_1, 32'd0);
      check("lit_dis_ram_en", ram_en, 32'd0);
      check("lit_dis_ram_we", ram_we, 32'd0);
    end
    tick(); idle(); #1;
    check("lit_dis_cnt_0", 32'(grant_cnt_0), 32'd4);
    check("lit_dis_cnt_1", 32'(grant_cnt_1), 32'd5);

    // Reset right after a read accept drops the response and restores priority.
    arb_en = 1'b1;
    tick(); drive(1'b1, 1'b0, 5'd7, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0); #1;
    check("lit_rst_rd_ready_0", req_ready_0, 32'd1);
    tick(); rst = 1'b1; idle(); #1;
    check("lit_rst_t1_resp_0", resp_valid_0, 32'd0);
    tick(); rst = 1'b0; #1;
    check("lit_rst_t2_resp_0", resp_valid_0, 32'd0);
    check("lit_rst_t2_resp_1", resp_valid_1, 32'd0);
    tick(); drive(1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0); #1;
    check("lit_rst_first_ready_0", req_ready_0, 32'd1);
    check("lit_rst_first_ready_1", req_ready_1, 32'd0);

    // Randomized traffic with occasional disable and reset.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst    = ($urandom_range(99) == 0);
      arb_en = ($urandom_range(9) != 0);
      drive(1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(3)), 32'($urandom),
            1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(3)), 32'($urandom));
    end

    // Port 0 counter saturation.
    tick(); rst = 1'b1; idle();
    tick(); rst = 1'b0; arb_en = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      drive(1'b1, 1'b1, 5'(i % DEPTH), 32'(i), 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
    end
    idle(); #1;
    check("lit_sat_cnt_0", 32'(grant_cnt_0), 32'h0000FFFF);
    check("lit_sat_cnt_1", 32'(grant_cnt_1), 32'd0);
    tick(); drive(1'b1, 1'b0, 5'd1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick(); idle(); tick(); #1;
    check("lit_sat_hold_cnt_0", 32'(grant_cnt_0), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
